// File: rtl/if_id_queue.sv
// if_id_queue: fetch/decode boundary buffer.
// A DEPTH-entry FIFO of {pc, inst} pairs with valid/ready handshakes on both
// sides. Branch redirects from EX or ID discard every entry. The global rdy
// input freezes all state. Output is show-ahead: the head entry is driven
// combinationally and forced to zero when the queue is empty.
// Optional build macro IFID_STATS_EN adds flush_drop_cnt / full_stall_cnt.
module if_id_queue #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush_ex,
    input  logic              flush_id,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INST_W-1:0] if_inst,
    output logic              if_ready,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    input  logic              id_ready,
`ifdef IFID_STATS_EN
    output logic [31:0]       flush_drop_cnt,
    output logic [31:0]       full_stall_cnt,
`endif
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = ADDR_W + INST_W;

    logic [ENT_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    logic [PTR_W-1:0] wr_ptr_nxt_s;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic [CNT_W-1:0] count_nxt_s;
    logic             flush_s;
    logic             push_s;
    logic             pop_s;
    logic             wr_en_s;
    logic [ENT_W-1:0] head_s;

    // Handshake decode; ready/valid depend only on the registered occupancy
    always_comb begin
        if_ready = (count_r != CNT_W'(DEPTH));
        id_valid = (count_r != {CNT_W{1'b0}});
        flush_s  = flush_ex | flush_id;
        push_s   = if_valid & if_ready;
        pop_s    = id_valid & id_ready;
        wr_en_s  = rdy & ~rst & ~flush_s & push_s;
        count    = count_r;
    end

    // Next-state for pointers and occupancy: hold on !rdy, clear on flush
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        if (!rdy) begin
            wr_ptr_nxt_s = wr_ptr_r;
            rd_ptr_nxt_s = rd_ptr_r;
            count_nxt_s  = count_r;
        end else if (flush_s) begin
            wr_ptr_nxt_s = {PTR_W{1'b0}};
            rd_ptr_nxt_s = {PTR_W{1'b0}};
            count_nxt_s  = {CNT_W{1'b0}};
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two
            if (push_s) begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CNT_W'(1);
                2'b01:   count_nxt_s = count_r - CNT_W'(1);
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Pointer and occupancy registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
        end
    end

    // Entry storage; contents are don't-care once the pointers are cleared
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= {if_pc, if_inst};
        end
    end

    // Show-ahead head entry, zeroed (bubble) when the queue is empty
    always_comb begin
        head_s = mem_r[rd_ptr_r];
        if (id_valid) begin
            id_pc   = head_s[ENT_W-1:INST_W];
            id_inst = head_s[INST_W-1:0];
        end else begin
            id_pc   = {ADDR_W{1'b0}};
            id_inst = {INST_W{1'b0}};
        end
    end

`ifdef IFID_STATS_EN
    logic [31:0] flush_drop_cnt_r;
    logic [31:0] full_stall_cnt_r;

    // Statistics: entries lost to redirects and cycles fetch was blocked
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_drop_cnt_r <= 32'd0;
            full_stall_cnt_r <= 32'd0;
        end else if (rdy) begin
            if (flush_s) begin
                flush_drop_cnt_r <= flush_drop_cnt_r + 32'(count_r);
            end
            if (if_valid && !if_ready) begin
                full_stall_cnt_r <= full_stall_cnt_r + 32'd1;
            end
        end
    end

    // Expose the statistics registers
    always_comb begin
        flush_drop_cnt = flush_drop_cnt_r;
        full_stall_cnt = full_stall_cnt_r;
    end
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: a table of directed vectors, a
// continuous push/pop sequence across pointer wrap, and randomized traffic,
// all compared each cycle against a queue-based reference model.
module tb_if_id_queue;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst;
    logic              rdy;
    logic              flush_ex;
    logic              flush_id;
    logic              if_valid;
    logic [ADDR_W-1:0] if_pc;
    logic [INST_W-1:0] if_inst;
    logic              if_ready;
    logic              id_valid;
    logic [ADDR_W-1:0] id_pc;
    logic [INST_W-1:0] id_inst;
    logic              id_ready;
    logic [CNT_W-1:0]  count;
`ifdef IFID_STATS_EN
    logic [31:0]       flush_drop_cnt;
    logic [31:0]       full_stall_cnt;
`endif

    if_id_queue #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush_ex(flush_ex), .flush_id(flush_id),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready),
        .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .id_ready(id_ready),
`ifdef IFID_STATS_EN
        .flush_drop_cnt(flush_drop_cnt), .full_stall_cnt(full_stall_cnt),
`endif
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: a plain queue of {pc, inst}
    logic [63:0] model_q [$];
    int unsigned model_drop  = 0;
    int unsigned model_stall = 0;
    bit          model_known = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int n;
        logic [63:0] head;
        n = model_q.size();
        head = (n != 0) ? model_q[0] : 64'd0;
        chk("count", 64'(count), 64'(n));
        chk("id_valid", 64'(id_valid), 64'(n != 0));
        chk("if_ready", 64'(if_ready), 64'(n != DEPTH));
        chk("id_pc", 64'(id_pc), 64'(head[63:32]));
        chk("id_inst", 64'(id_inst), 64'(head[31:0]));
`ifdef IFID_STATS_EN
        chk("flush_drop_cnt", 64'(flush_drop_cnt), 64'(model_drop));
        chk("full_stall_cnt", 64'(full_stall_cnt), 64'(model_stall));
`endif
    endtask

    // Drive one cycle: check current outputs, advance the model, clock once.
    task automatic step(input logic t_rst, input logic t_rdy, input logic t_fe,
                        input logic t_fi, input logic t_v, input logic [31:0] t_pc,
                        input logic [31:0] t_inst, input logic t_idr);
        int n;
        rst = t_rst; rdy = t_rdy; flush_ex = t_fe; flush_id = t_fi;
        if_valid = t_v; if_pc = t_pc; if_inst = t_inst; id_ready = t_idr;
        #1;
        if (model_known) check_model();
        n = model_q.size();
        if (t_rst) begin
            model_q.delete();
            model_drop  = 0;
            model_stall = 0;
            model_known = 1;
        end else if (t_rdy) begin
            if (t_v && n == DEPTH) model_stall++;
            if (t_fe || t_fi) begin
                model_drop += n;
                model_q.delete();
            end else begin
                if (t_idr && n != 0) void'(model_q.pop_front());
                if (t_v && n != DEPTH) model_q.push_back({t_pc, t_inst});
            end
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst, rdy, fe, fi, v;
        logic [31:0] pc;
        logic        idr;
        int          cnt;
        logic        vld, rdo;
        logic [31:0] epc;
    } vec_t;

    function automatic vec_t mk(logic r, logic y, logic fe, logic fi, logic v,
                                logic [31:0] pc, logic idr, int cnt, logic vld,
                                logic rdo, logic [31:0] epc);
        vec_t t;
        t.rst = r; t.rdy = y; t.fe = fe; t.fi = fi; t.v = v; t.pc = pc; t.idr = idr;
        t.cnt = cnt; t.vld = vld; t.rdo = rdo; t.epc = epc;
        return t;
    endfunction

    vec_t tbl [23];

    initial begin
        logic [31:0] pc;
        rst = 1'b1; rdy = 1'b1; flush_ex = 1'b0; flush_id = 1'b0;
        if_valid = 1'b0; if_pc = '0; if_inst = '0; id_ready = 1'b0;

        //              rst  rdy  fe   fi   v    pc      idr  cnt vld  rdo  exp_pc
        tbl[0]  = mk(1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,   1'b0,0,1'b0,1'b1,32'h0);
        tbl[1]  = mk(1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,   1'b1,0,1'b0,1'b1,32'h0);
        tbl[2]  = mk(1'b0,1'b1,1'b0,1'b0,1'b1,32'h0,   1'b0,1,1'b1,1'b1,32'h0);
        tbl[3]  = mk(1'b0,1'b1,1'b0,1'b0,1'b1,32'h4,   1'b0,2,1'b1,1'b1,32'h0);
        tbl[4]  = mk(1'b0,1'b1,1'b0,1'b0,1'b1,32'h8,   1'b0,3,1'b1,1'b1,32'h0);
        tbl[5]  = mk(1'b0,1'b1,1'b0,1'b0,1'b1,32'hC,   1'b0,4,1'b1,1'b0,32'h0);
        tbl[6]  = mk(1'b0,1'b1,1'b0,1'b0,1'b1,32'h10,  1'b0,4,1'b1,1'b0,32'h0);
        tbl[7]  = mk(1'b0,1'b1,1'b0,1'b0,1'b1,32'h10,  1'b1,3,1'b1,1'b1,32'h4);
        tbl[8]  = mk(1'b0,1'b1,1'b0,1'b0,1'b1,32'h10,  1'b0,4,1'b1,1'b0,32'h4);
        tbl[9]  = mk(1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,   1'b1,3,1'b1,1'b1,32'h8);
        tbl[10] = mk(1'b0,1'b1,1'b1,1'b0,1'b1,32'h200, 1'b0,0,1'b0,1'b1,32'h0);
        tbl[11] = mk(1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,   1'b1,0,1'b0,1'b1,32'h0);
        tbl[12] = mk(1'b0,1'b1,1'b0,1'b0,1'b1,32'h300, 1'b0,1,1'b1,1'b1,32'h300);
        tbl[13] = mk(1'b0,1'b1,1'b0,1'b0,1'b1,32'h304, 1'b0,2,1'b1,1'b1,32'h300);
        tbl[14] = mk(1'b0,1'b0,1'b0,1'b0,1'b1,32'h308, 1'b1,2,1'b1,1'b1,32'h300);
        tbl[15] = mk(1'b0,1'b0,1'b0,1'b0,1'b1,32'h308, 1'b1,2,1'b1,1'b1,32'h300);
        tbl[16] = mk(1'b0,1'b0,1'b1,1'b0,1'b1,32'h308, 1'b1,2,1'b1,1'b1,32'h300);
        tbl[17] = mk(1'b0,1'b1,1'b0,1'b0,1'b1,32'h308, 1'b1,2,1'b1,1'b1,32'h304);
        tbl[18] = mk(1'b0,1'b1,1'b0,1'b0,1'b1,32'h30C, 1'b0,3,1'b1,1'b1,32'h304);
        tbl[19] = mk(1'b0,1'b1,1'b0,1'b0,1'b1,32'h310, 1'b0,4,1'b1,1'b0,32'h304);
        tbl[20] = mk(1'b1,1'b1,1'b0,1'b1,1'b1,32'h314, 1'b1,0,1'b0,1'b1,32'h0);
        tbl[21] = mk(1'b0,1'b1,1'b0,1'b0,1'b1,32'h400, 1'b0,1,1'b1,1'b1,32'h400);
        tbl[22] = mk(1'b1,1'b0,1'b0,1'b0,1'b1,32'h404, 1'b0,0,1'b0,1'b1,32'h0);

        @(posedge clk);
        #1;
        for (int i = 0; i < 23; i++) begin
            step(tbl[i].rst, tbl[i].rdy, tbl[i].fe, tbl[i].fi, tbl[i].v,
                 tbl[i].pc, tbl[i].pc ^ 32'h0000_0013, tbl[i].idr);
            chk($sformatf("vec%0d_count", i), 64'(count), 64'(tbl[i].cnt));
            chk($sformatf("vec%0d_id_valid", i), 64'(id_valid), 64'(tbl[i].vld));
            chk($sformatf("vec%0d_if_ready", i), 64'(if_ready), 64'(tbl[i].rdo));
            chk($sformatf("vec%0d_id_pc", i), 64'(id_pc), 64'(tbl[i].epc));
            if (!tbl[i].vld) chk($sformatf("vec%0d_id_inst", i), 64'(id_inst), 64'd0);
`ifdef IFID_STATS_EN
            if (i == 10) chk("flush_drop_after_flush", 64'(flush_drop_cnt), 64'd3);
`endif
        end

        // Continuous push and pop across pointer wrap, occupancy held at one
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h0010_0093, 1'b0);
        chk("stream_first_pc", 64'(id_pc), 64'h100);
        for (int i = 0; i < 10; i++) begin
            pc = 32'h104 + 32'(4 * i);
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, pc, pc ^ 32'h0000_0013, 1'b1);
            chk($sformatf("stream%0d_count", i), 64'(count), 64'd1);
            chk($sformatf("stream%0d_id_pc", i), 64'(id_pc), 64'(pc));
        end

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(63) == 0, $urandom_range(7) != 0,
                 $urandom_range(15) == 0, $urandom_range(15) == 0,
                 $urandom_range(3) != 0, $urandom & 32'hFFFF_FFFC, $urandom,
                 $urandom_range(1) == 1);
        end
        if (model_known) check_model();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
Parametrised fetch/decode boundary buffer that replaces the single IF/ID pipeline register with a DEPTH-entry FIFO of {pc, inst} pairs.
- Both sides use valid/ready handshakes, so fetch keeps running while decode stalls.
- Branch redirects from EX or ID flush the whole buffer.
- Sits between the fetch unit and the decoder; honours the global rdy pause.

Parameters:
ADDR_W, 32, pc width in bits
INST_W, 32, instruction width in bits
DEPTH, 4, queue entries; power of two, >= 2
CNT_W, $clog2(DEPTH)+1, occupancy counter width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rdy  in  1  global ready; 0 freezes all state
flush_ex  in  1  EX-stage jump; discard all entries
flush_id  in  1  ID-stage jump; discard all entries
if_valid  in  1  fetch presents an instruction
if_pc  in  ADDR_W  fetched pc
if_inst  in  INST_W  fetched instruction
if_ready  out  1  queue accepts a push
id_valid  out  1  head entry valid
id_pc  out  ADDR_W  head pc; 0 when empty
id_inst  out  INST_W  head instruction; 0 when empty (bubble/NOP)
id_ready  in  1  decoder consumes head
count  out  CNT_W  current occupancy

Behaviour:
- Reset: wr_ptr=0, rd_ptr=0, count=0, id_valid=0, id_pc=0, id_inst=0, if_ready=1.
- Priority in each cycle: rst > !rdy > (flush_ex | flush_id) > push/pop.
- push = if_valid & if_ready; pop = id_valid & id_ready.
- if_ready = (count != DEPTH); id_valid = (count != 0). Both derived from registered count only.
- Storage:
  - Push writes {if_pc, if_inst} at wr_ptr, then wr_ptr += 1 mod DEPTH.
  - Pop advances rd_ptr mod DEPTH. Pointer wrap is natural modulo.
- Output is show-ahead: id_pc/id_inst combinationally reflect the entry at rd_ptr, forced to 0 when count==0.
- Latency: an entry pushed in cycle N is first visible on id_* in cycle N+1. There is no same-cycle bypass.
- Simultaneous push and pop (0 < count < DEPTH): both occur and count is unchanged.
- Full: if_ready=0, so a pop in that cycle does not enable a same-cycle push. The push is accepted in the next cycle.
- Empty: id_valid=0; id_ready is ignored and count never underflows.
- Flush (either source):
  - Next cycle: count=0, wr_ptr=rd_ptr=0.
  - Any push or pop in the flush cycle is discarded.
  - Storage contents are don't-care.
- rdy=0: pointers, count and storage hold. Outputs keep their values, and no transfer occurs regardless of the handshakes.
- rst mid-operation clears all state next edge regardless of rdy or flush.

Optional Feature:
IFID_STATS_EN
- With the macro, two extra outputs are present, each 32 bits, cleared on rst, frozen when rdy=0, wrapping at 2^32:
  - flush_drop_cnt: adds count on each flush cycle.
  - full_stall_cnt: increments each cycle with if_valid & !if_ready.
- Without the macro, these ports and registers do not exist and the behaviour is otherwise identical.

Test Plan:
- Reset, then push pc=0x0,0x4,0x8 with id_ready=0 -> count=3, id_pc=0x0, id_valid=1; empty before first push shows id_pc=0, id_inst=0.
- DEPTH=4: push 5 instructions with id_ready=0 -> if_ready=0 after the 4th, count=4. Raise id_ready for one cycle -> pops 0x0; 5th push (pc=0x10) accepted the following cycle.
- Continuous push and pop for 10 cycles starting at pc=0x100 -> count stays 1, id_pc sequence 0x100,0x104,... in order across pointer wrap.
- count=3, assert flush_ex together with if_valid (pc=0x200) -> next cycle count=0, id_valid=0, id_pc=0; 0x200 not stored. With IFID_STATS_EN, flush_drop_cnt=3.
- count=2, hold rdy=0 for 3 cycles with if_valid=1 and id_ready=1 -> count stays 2 and id_pc unchanged; resumes normally on rdy=1.
- Assert rst while count=4 and flush_id=1 -> next cycle all outputs at reset values, if_ready=1.
